// File: rtl/sha_round_ctrl_if.sv
// Handshake/data bundle between the SHA-256 round controller and its environment
// (start/block in, adder results in, working state, schedule window, K and digest out).
`timescale 1ns/1ps
interface sha_round_ctrl_if;
  logic         i_start;
  logic         i_first;
  logic [511:0] i_block;
  logic [31:0]  i_new_a;
  logic [31:0]  i_new_d;
  logic [31:0]  i_new_word;
  logic [255:0] o_state;
  logic [511:0] o_words;
  logic [31:0]  o_kt;
  logic         o_busy;
  logic         o_done;
  logic [255:0] o_digest;

  modport master (
    output i_start, i_first, i_block, i_new_a, i_new_d, i_new_word,
    input  o_state, o_words, o_kt, o_busy, o_done, o_digest
  );

  modport slave (
    input  i_start, i_first, i_block, i_new_a, i_new_d, i_new_word,
    output o_state, o_words, o_kt, o_busy, o_done, o_digest
  );
endinterface

// File: rtl/sha_round_ctrl.sv
// SHA-256 round controller: working vars, 16-word schedule window, round counter, K ROM, digest.
// Optional macro SHA_CHAIN_EN: i_first selects H0 or the previous digest as init (multi-block).
//
// state | meaning
// IDLE  | waiting for i_start; digest held
// ROUND | one compression round per cycle, adder results absorbed
// FINAL | add chaining value, pulse o_done
`timescale 1ns/1ps
module sha_round_ctrl #(
  parameter int           ROUNDS = 64,
  parameter logic [255:0] H0     = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sha_round_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  localparam logic [0:63][31:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t         fsm;
  logic [5:0]     round;
  logic [255:0]   init_q;
  logic [255:0]   init_sel;
  logic [255:0]   digest_sum;

`ifdef SHA_CHAIN_EN
  assign init_sel = bus.i_first ? H0 : bus.o_digest;
`else
  logic unused_first;
  assign unused_first = bus.i_first;
  assign init_sel     = H0;
`endif

  assign bus.o_kt = (fsm == ROUND) ? K_ROM[round] : 32'h0;

  // Feed-forward uses the init vector latched at start, never the live ports.
  always_comb begin
    digest_sum = '0;
    for (int i = 0; i < 8; i++) begin
      digest_sum[32*i +: 32] = init_q[32*i +: 32] + bus.o_state[32*i +: 32];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm          <= IDLE;
      round        <= '0;
      init_q       <= '0;
      bus.o_state  <= '0;
      bus.o_words  <= '0;
      bus.o_busy   <= 1'b0;
      bus.o_done   <= 1'b0;
      bus.o_digest <= '0;
    end else begin
      bus.o_done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (bus.i_start) begin
            bus.o_words <= bus.i_block;
            bus.o_state <= init_sel;
            init_q      <= init_sel;
            round       <= '0;
            bus.o_busy  <= 1'b1;
            fsm         <= ROUND;
          end
        end
        ROUND: begin
          bus.o_state <= {bus.i_new_a, bus.o_state[255:160], bus.i_new_d, bus.o_state[127:32]};
          bus.o_words <= {bus.o_words[479:0], bus.i_new_word};
          // Counter parks on the last round; it is only reloaded by the next start.
          if (round == LAST_ROUND) begin
            fsm <= FINAL;
          end else begin
            round <= round + 6'd1;
          end
        end
        FINAL: begin
          bus.o_digest <= digest_sum;
          bus.o_done   <= 1'b1;
          bus.o_busy   <= 1'b0;
          fsm          <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Self-checking bench for sha_round_ctrl: behavioural function units/adder around the DUT,
// known-answer table, corner-case sequences and random blocks against a SHA-256 reference.
`timescale 1ns/1ps
module tb_sha_round_ctrl;

  localparam logic [255:0] H0_TB = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_BLK1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                       32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                       32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                       32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_BLK2 = {480'h0, 32'h000001c0};

  localparam logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    string        name;
    logic [511:0] block;
    logic         first;
    logic [255:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [255:0] prev_exp;

  sha_round_ctrl_if bus ();

  sha_round_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Environment: the function units plus sha_adder, combinational from the DUT outputs.
  logic [31:0] sa, sb, sc, sd, se, sf, sg, sh, t1, t2;
  assign {sa, sb, sc, sd, se, sf, sg, sh} = bus.o_state;
  assign t1 = sh + bsig1(se) + ((se & sf) ^ (~se & sg)) + bus.o_kt + bus.o_words[511:480];
  assign t2 = bsig0(sa) + ((sa & sb) ^ (sa & sc) ^ (sb & sc));
  assign bus.i_new_a = t1 + t2;
  assign bus.i_new_d = sd + t1;
  assign bus.i_new_word = ssig1(bus.o_words[63:32]) + bus.o_words[223:192]
                        + ssig0(bus.o_words[479:448]) + bus.o_words[511:480];

  function automatic void expand(input logic [511:0] blk, output logic [31:0] w [64]);
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
  endfunction

  function automatic logic [255:0] sha_ref(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] x1, x2;
    logic [255:0] res;
    expand(blk, w);
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      x1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TB[t] + w[t];
      x2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return res;
  endfunction

  function automatic logic [255:0] init_for(input logic first);
`ifdef SHA_CHAIN_EN
    return first ? H0_TB : prev_exp;
`else
    return (first | 1'b1) ? H0_TB : prev_exp;
`endif
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called between edges; the start is sampled at the next rising edge.
  task automatic start_block(input logic [511:0] blk, input logic first);
    bus.i_start = 1'b1;
    bus.i_block = blk;
    bus.i_first = first;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.o_done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_one(input string name, input logic [511:0] blk, input logic first,
                         input logic [255:0] exp);
    int lat;
    @(negedge clk);
    start_block(blk, first);
    chk({name, " busy"}, 512'(bus.o_busy), 512'd1);
    wait_done(lat);
    chk({name, " latency"}, 512'(lat), 512'd65);
    chk({name, " digest"}, 512'(bus.o_digest), 512'(exp));
    prev_exp = exp;
    @(posedge clk);
    #1;
    chk({name, " done pulse"}, 512'(bus.o_done), 512'd0);
    chk({name, " busy drop"}, 512'(bus.o_busy), 512'd0);
  endtask

  initial begin
    vec_t tbl [3];
    logic [31:0] w [64];
    logic [511:0] blk;
    logic first;
    logic [255:0] exp;
    int lat, ndone, done_c;

    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_first = 1'b0;
    bus.i_block = '0;
    prev_exp = '0;
    repeat (2) @(negedge clk);
    chk("reset state", 512'(bus.o_state), 512'd0);
    chk("reset words", bus.o_words, 512'd0);
    chk("reset kt", 512'(bus.o_kt), 512'd0);
    chk("reset busy", 512'(bus.o_busy), 512'd0);
    chk("reset done", 512'(bus.o_done), 512'd0);
    chk("reset digest", 512'(bus.o_digest), 512'd0);
    rst_n = 1'b1;

    tbl[0] = '{"abc", ABC_BLK, 1'b1, ABC_DIG};
    tbl[1] = '{"empty", EMPTY_BLK, 1'b1, EMPTY_DIG};
`ifdef SHA_CHAIN_EN
    tbl[2] = '{"abc chained", ABC_BLK, 1'b0, sha_ref(EMPTY_DIG, ABC_BLK)};
`else
    tbl[2] = '{"abc first0", ABC_BLK, 1'b0, ABC_DIG};
`endif
    for (int i = 0; i < 3; i++) run_one(tbl[i].name, tbl[i].block, tbl[i].first, tbl[i].exp);

    // Per-round K and W[t] on the "abc" block.
    expand(ABC_BLK, w);
    @(negedge clk);
    start_block(ABC_BLK, 1'b1);
    for (int t = 0; t < 64; t++) begin
      chk($sformatf("kt t=%0d", t), 512'(bus.o_kt), 512'(K_TB[t]));
      chk($sformatf("w t=%0d", t), 512'(bus.o_words[511:480]), 512'(w[t]));
      @(posedge clk);
      #1;
    end
    chk("final kt", 512'(bus.o_kt), 512'd0);
    chk("final busy", 512'(bus.o_busy), 512'd1);
    chk("final no done yet", 512'(bus.o_done), 512'd0);
    @(posedge clk);
    #1;
    chk("perround done", 512'(bus.o_done), 512'd1);
    chk("perround digest", 512'(bus.o_digest), 512'(ABC_DIG));
    prev_exp = ABC_DIG;

    // Two blocks, second start in the o_done cycle.
    @(negedge clk);
    start_block(TWO_BLK1, 1'b1);
    wait_done(lat);
    exp = sha_ref(H0_TB, TWO_BLK1);
    chk("two blk1 latency", 512'(lat), 512'd65);
    chk("two blk1 digest", 512'(bus.o_digest), 512'(exp));
    prev_exp = exp;
    start_block(TWO_BLK2, 1'b0);
    chk("two blk2 busy", 512'(bus.o_busy), 512'd1);
    wait_done(lat);
`ifdef SHA_CHAIN_EN
    exp = TWO_DIG;
`else
    exp = sha_ref(H0_TB, TWO_BLK2);
`endif
    chk("two blk2 latency", 512'(lat), 512'd65);
    chk("two blk2 digest", 512'(bus.o_digest), 512'(exp));
    prev_exp = exp;

    // Start pulses at rounds 0, 30, 63 must be ignored.
    @(negedge clk);
    start_block(ABC_BLK, 1'b1);
    ndone = 0;
    done_c = -1;
    for (int c = 0; c < 75; c++) begin
      if (bus.o_done) begin
        ndone++;
        done_c = c;
      end
      bus.i_start = (c == 0 || c == 30 || c == 63);
      bus.i_block = EMPTY_BLK;
      @(posedge clk);
      #1;
    end
    bus.i_start = 1'b0;
    chk("busy start count", 512'(ndone), 512'd1);
    chk("busy start cycle", 512'(done_c), 512'd65);
    chk("busy start digest", 512'(bus.o_digest), 512'(ABC_DIG));
    chk("busy start idle", 512'(bus.o_busy), 512'd0);
    prev_exp = ABC_DIG;

    // Reset at round 40.
    @(negedge clk);
    start_block(ABC_BLK, 1'b1);
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    chk("pre-reset busy", 512'(bus.o_busy), 512'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 512'(bus.o_busy), 512'd0);
    chk("abort digest", 512'(bus.o_digest), 512'd0);
    chk("abort state", 512'(bus.o_state), 512'd0);
    chk("abort kt", 512'(bus.o_kt), 512'd0);
    prev_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_done) ndone++;
    end
    chk("abort no done", 512'(ndone), 512'd0);
    run_one("abc after reset", ABC_BLK, 1'b1, ABC_DIG);

    // Random blocks against the reference model.
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 16; j++) blk[32*j +: 32] = $urandom;
      first = 1'($urandom_range(0, 1));
      exp = sha_ref(init_for(first), blk);
      run_one($sformatf("rand%0d", r), blk, first, exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
